// File: rtl/rv_mem_pkg.sv
// Shared load/store encodings and helpers for the MEM stage.
// Combinational helpers only, no latency.
// No flow control; pure functions and types.
package rv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} sizeT;

  typedef enum logic {IDLE, WAIT} lsuStateT;

  // funct3 values 3, 6 and 7 have no load/store meaning and are trapped.
  function automatic logic validF3(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW};
  endfunction

  function automatic sizeT f3Size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic isAligned(input sizeT sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return ~a[0];
      default: return (a == 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] byteEn(input sizeT sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store value across lanes so byte enables alone pick the target.
  function automatic logic [31:0] laneData(input sizeT sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] loadExtend(input sizeT sz, input logic uns,
                                             input logic [1:0] a, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_B:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Data RAM: four byte lanes with per-lane write enable.
// Write at posedge; read combinational (READ_LATENCY=0) or one posedge later (=1).
// No flow control; the caller sequences reads around the read latency.
module dmem_bank #(
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] rdRaw;

  for (genvar l = 0; l < 4; l++) begin : gLane
    logic [7:0] mem [DEPTH];

    // Write this lane only when its byte enable is set
    always_ff @(posedge clk) begin
      if (we && be[l]) mem[addr] <= wdata[8*l +: 8];
    end

    assign rdRaw[8*l +: 8] = mem[addr];
  end

  if (READ_LATENCY == 0) begin : gCombRead
    assign rdata = rdRaw;
  end else begin : gRegRead
    // Registered read port; address is held by the pipeline for the wait cycle
    always_ff @(posedge clk) begin
      rdata <= rdRaw;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: alignment check, byte-lane steering, load extension, MEM/WB register.
// Latency 1 cycle; with READ_LATENCY=1 loads take 2 (one stall cycle).
// Raises stallM for one cycle per aligned load when the RAM read is registered.
module mem_stage_lsu
  import rv_mem_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteM,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  funct3M,
  input  logic [1:0]  wbselM,
  input  logic [4:0]  rdM,
  input  logic [31:0] data_writeM,
  input  logic [31:0] ALUresM,
  input  logic [31:0] pc4M,
  output logic        stallM,
  output logic        regwriteW,
  output logic [1:0]  wbselW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUresW,
  output logic [31:0] data_readW,
  output logic [31:0] pc4W,
  output logic        misalignW
);

  localparam int AW = $clog2(DEPTH);

  sizeT        sizeM;
  logic        misalignM;
  logic        loadM;
  logic        storeM;
  logic [31:0] rdWord;
  logic [31:0] loadData;
  lsuStateT    state;
  lsuStateT    stateNext;
  logic        bubble;

  assign sizeM     = f3Size(funct3M);
  assign misalignM = (memreadM | memwriteM) &
                     ~(validF3(funct3M) & isAligned(sizeM, ALUresM[1:0]));
  // A combined read+write is a store: write wins and no load data returns.
  assign storeM    = memwriteM & ~misalignM;
  assign loadM     = memreadM & ~memwriteM & ~misalignM;
  assign loadData  = loadExtend(sizeM, funct3M[2], ALUresM[1:0], rdWord);

  // Upper address bits are dropped so out-of-range addresses wrap.
  dmem_bank #(
    .DEPTH        (DEPTH),
    .READ_LATENCY (READ_LATENCY)
  ) uBank (
    .clk   (clk),
    .addr  (ALUresM[AW+1:2]),
    .be    (byteEn(sizeM, ALUresM[1:0])),
    .we    (storeM & ~rst),
    .wdata (laneData(sizeM, data_writeM)),
    .rdata (rdWord)
  );

  // Load-wait state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state, stall request and MEM/WB bubble for registered-read loads
  always_comb begin
    stateNext = state;
    stallM    = 1'b0;
    bubble    = 1'b0;
    if (READ_LATENCY != 0) begin
      case (state)
        IDLE: begin
          if (loadM && !rst) begin
            stallM    = 1'b1;
            bubble    = 1'b1;
            stateNext = WAIT;
          end
        end
        WAIT:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      regwriteW  <= 1'b0;
      wbselW     <= 2'd0;
      rdW        <= 5'd0;
      ALUresW    <= 32'd0;
      data_readW <= 32'd0;
      pc4W       <= 32'd0;
      misalignW  <= 1'b0;
    end else begin
      regwriteW  <= regwriteM & ~misalignM;
      wbselW     <= wbselM;
      rdW        <= rdM;
      ALUresW    <= ALUresM;
      data_readW <= loadM ? loadData : 32'd0;
      pc4W       <= pc4M;
      misalignW  <= misalignM;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a combinational-read and a registered-read instance
// share one input stream; inputs are held while the registered-read one stalls.
module tb_mem_stage_lsu;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [1:0]  wbsel;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc4;
  } opT;

  typedef struct packed {
    logic        regwrite;
    logic [1:0]  wbsel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] pc4;
    logic        mis;
  } wbT;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwriteM, memreadM, memwriteM;
  logic [2:0]  funct3M;
  logic [1:0]  wbselM;
  logic [4:0]  rdM;
  logic [31:0] data_writeM, ALUresM, pc4M;

  logic        stallA, regwriteWA, misalignWA;
  logic [1:0]  wbselWA;
  logic [4:0]  rdWA;
  logic [31:0] ALUresWA, data_readWA, pc4WA;
  logic        stallB, regwriteWB, misalignWB;
  logic [1:0]  wbselWB;
  logic [4:0]  rdWB;
  logic [31:0] ALUresWB, data_readWB, pc4WB;
  wbT          wA, wB;

  logic [7:0]  mem [1024];
  int          nPass  = 0;
  int          nTotal = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DEPTH(256), .READ_LATENCY(0)) dutA (
    .clk(clk), .rst(rst), .regwriteM(regwriteM), .memreadM(memreadM), .memwriteM(memwriteM),
    .funct3M(funct3M), .wbselM(wbselM), .rdM(rdM), .data_writeM(data_writeM), .ALUresM(ALUresM),
    .pc4M(pc4M), .stallM(stallA), .regwriteW(regwriteWA), .wbselW(wbselWA), .rdW(rdWA),
    .ALUresW(ALUresWA), .data_readW(data_readWA), .pc4W(pc4WA), .misalignW(misalignWA));

  mem_stage_lsu #(.DEPTH(256), .READ_LATENCY(1)) dutB (
    .clk(clk), .rst(rst), .regwriteM(regwriteM), .memreadM(memreadM), .memwriteM(memwriteM),
    .funct3M(funct3M), .wbselM(wbselM), .rdM(rdM), .data_writeM(data_writeM), .ALUresM(ALUresM),
    .pc4M(pc4M), .stallM(stallB), .regwriteW(regwriteWB), .wbselW(wbselWB), .rdW(rdWB),
    .ALUresW(ALUresWB), .data_readW(data_readWB), .pc4W(pc4WB), .misalignW(misalignWB));

  assign wA = {regwriteWA, wbselWA, rdWA, ALUresWA, data_readWA, pc4WA, misalignWA};
  assign wB = {regwriteWB, wbselWB, rdWB, ALUresWB, data_readWB, pc4WB, misalignWB};

  function automatic opT mkOp(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data);
    opT o;
    o.rw = rw; o.mr = mr; o.mw = mw; o.f3 = f3; o.wbsel = 2'd1; o.rd = rd;
    o.addr = addr; o.data = data; o.pc4 = 32'h100 + addr;
    return o;
  endfunction

  // Load data is only meaningful for loads; blank it elsewhere before comparing.
  function automatic wbT keepData(input wbT w, input logic ld);
    wbT r;
    r = w;
    if (!ld) r.data = 32'd0;
    return r;
  endfunction

  // Reference: byte-addressed memory of 1024 bytes (256 words), address taken mod 1024.
  task automatic modelOp(input opT op, output wbT e, output logic ld);
    int sz, a;
    logic mis, st;
    logic [31:0] v;
    sz  = 1 << op.f3[1:0];
    mis = (op.mr || op.mw) && (op.f3 == 3'd3 || op.f3 == 3'd6 || op.f3 == 3'd7 || (op.addr % sz) != 0);
    ld  = op.mr && !op.mw && !mis;
    st  = op.mw && !mis;
    a   = int'(op.addr[9:0]);
    v   = 32'd0;
    if (ld) begin
      for (int i = 0; i < sz; i++) v = v | (32'(mem[(a + i) % 1024]) << (8 * i));
      if (!op.f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    end
    if (st) for (int i = 0; i < sz; i++) mem[(a + i) % 1024] = op.data[8*i +: 8];
    e.regwrite = op.rw & ~mis;
    e.wbsel    = op.wbsel;
    e.rd       = op.rd;
    e.alu      = op.addr;
    e.data     = v;
    e.pc4      = op.pc4;
    e.mis      = mis;
  endtask

  task automatic drive(input opT op);
    regwriteM = op.rw; memreadM = op.mr; memwriteM = op.mw; funct3M = op.f3;
    wbselM = op.wbsel; rdM = op.rd; ALUresM = op.addr; data_writeM = op.data; pc4M = op.pc4;
  endtask

  // Issue one op; hold it one more cycle if the registered-read instance stalls.
  task automatic runOp(input opT op, output wbT oA, output wbT oB, output wbT bub,
                       output logic s1, output logic s2, output logic sA);
    @(negedge clk);
    drive(op);
    #1;
    s1 = stallB;
    sA = stallA;
    @(posedge clk);
    #1;
    oA = wA; oB = wB; bub = '0; s2 = 1'b0;
    if (s1) begin
      bub = wB;
      @(negedge clk);
      #1;
      s2 = stallB;
      sA = sA | stallA;
      @(posedge clk);
      #1;
      oA = wA; oB = wB;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    drive(mkOp(1, 1, 0, 3'd2, 5'd3, 32'h10, 32'd0));
    #1;
    nTotal++; if ({stallA, stallB} !== 2'b00) $display("FAIL reset_stall got %b want 00", {stallA, stallB}); else nPass++;
    @(posedge clk);
    #1;
    nTotal++; if (wA !== '0) $display("FAIL reset_wA got %h want 0", wA); else nPass++;
    nTotal++; if (wB !== '0) $display("FAIL reset_wB got %h want 0", wB); else nPass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill;
    wbT oA, oB, bub, e;
    logic s1, s2, sA, ld;
    opT op;
    for (int w = 0; w < 256; w++) begin
      op = mkOp(0, 0, 1, 3'd2, 5'd0, 32'(w * 4), $urandom);
      modelOp(op, e, ld);
      runOp(op, oA, oB, bub, s1, s2, sA);
    end
  endtask

  task automatic test_word;
    wbT oA, oB, bub, e;
    logic s1, s2, sA, ld;
    modelOp(mkOp(0, 0, 1, 3'd2, 5'd0, 32'h10, 32'hDEADBEEF), e, ld);
    runOp(mkOp(0, 0, 1, 3'd2, 5'd0, 32'h10, 32'hDEADBEEF), oA, oB, bub, s1, s2, sA);
    modelOp(mkOp(1, 1, 0, 3'd2, 5'd5, 32'h10, 32'd0), e, ld);
    runOp(mkOp(1, 1, 0, 3'd2, 5'd5, 32'h10, 32'd0), oA, oB, bub, s1, s2, sA);
    nTotal++; if (oA.data !== 32'hDEADBEEF) $display("FAIL lw_A_data got %h want deadbeef", oA.data); else nPass++;
    nTotal++; if (oB.data !== 32'hDEADBEEF) $display("FAIL lw_B_data got %h want deadbeef", oB.data); else nPass++;
    nTotal++; if ({oA.regwrite, oA.mis, oB.regwrite, oB.mis} !== 4'b1010)
      $display("FAIL lw_flags got %b want 1010", {oA.regwrite, oA.mis, oB.regwrite, oB.mis}); else nPass++;
    nTotal++; if (oB !== e) $display("FAIL lw_B_full got %h want %h", oB, e); else nPass++;
  endtask

  task automatic test_subword;
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ads  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] want [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    wbT oA, oB, bub;
    logic s1, s2, sA;
    for (int i = 0; i < 4; i++) begin
      runOp(mkOp(1, 1, 0, f3s[i], 5'd6, ads[i], 32'd0), oA, oB, bub, s1, s2, sA);
      nTotal++; if (oA.data !== want[i]) $display("FAIL subword%0d_A got %h want %h", i, oA.data, want[i]); else nPass++;
      nTotal++; if (oB.data !== want[i]) $display("FAIL subword%0d_B got %h want %h", i, oB.data, want[i]); else nPass++;
    end
  endtask

  task automatic test_sb;
    wbT oA, oB, bub, e;
    logic s1, s2, sA, ld;
    modelOp(mkOp(0, 0, 1, 3'd0, 5'd0, 32'h11, 32'hAAAAAA55), e, ld);
    runOp(mkOp(0, 0, 1, 3'd0, 5'd0, 32'h11, 32'hAAAAAA55), oA, oB, bub, s1, s2, sA);
    runOp(mkOp(1, 1, 0, 3'd2, 5'd8, 32'h10, 32'd0), oA, oB, bub, s1, s2, sA);
    nTotal++; if (oA.data !== 32'hDEAD55EF) $display("FAIL sb_A got %h want dead55ef", oA.data); else nPass++;
    nTotal++; if (oB.data !== 32'hDEAD55EF) $display("FAIL sb_B got %h want dead55ef", oB.data); else nPass++;
  endtask

  task automatic test_misalign;
    wbT oA, oB, bub, e;
    logic s1, s2, sA, ld;
    opT ops [3];
    ops[0] = mkOp(1, 1, 0, 3'd2, 5'd9, 32'h12, 32'd0);
    ops[1] = mkOp(1, 0, 1, 3'd1, 5'd9, 32'h11, 32'h0000FFFF);
    ops[2] = mkOp(1, 1, 0, 3'd3, 5'd9, 32'h10, 32'd0);
    for (int i = 0; i < 3; i++) begin
      modelOp(ops[i], e, ld);
      runOp(ops[i], oA, oB, bub, s1, s2, sA);
      nTotal++; if ({oA.regwrite, oA.mis, oB.regwrite, oB.mis, s1} !== 5'b01010)
        $display("FAIL misalign%0d got %b want 01010", i, {oA.regwrite, oA.mis, oB.regwrite, oB.mis, s1}); else nPass++;
      nTotal++; if (keepData(oB, 1'b0) !== keepData(e, 1'b0)) $display("FAIL misalign%0d_pass got %h want %h", i, oB, e); else nPass++;
    end
    runOp(mkOp(1, 1, 0, 3'd2, 5'd9, 32'h10, 32'd0), oA, oB, bub, s1, s2, sA);
    nTotal++; if (oB.data !== 32'hDEAD55EF) $display("FAIL misalign_ram got %h want dead55ef", oB.data); else nPass++;
  endtask

  task automatic test_back_to_back;
    wbT oA, oB, bub, e;
    logic s1, s2, sA, ld;
    opT op;
    for (int i = 0; i < 2; i++) begin
      op = mkOp(1, 1, 0, 3'd2, 5'd10 + 5'(i), 32'h14 + 32'(4 * i), 32'd0);
      modelOp(op, e, ld);
      runOp(op, oA, oB, bub, s1, s2, sA);
      nTotal++; if ({s1, s2} !== 2'b10) $display("FAIL b2b%0d_stall got %b want 10", i, {s1, s2}); else nPass++;
      nTotal++; if ({bub.regwrite, bub.rd, bub.mis} !== 7'd0)
        $display("FAIL b2b%0d_bubble got %b want 0", i, {bub.regwrite, bub.rd, bub.mis}); else nPass++;
      nTotal++; if (oB !== e) $display("FAIL b2b%0d_B got %h want %h", i, oB, e); else nPass++;
    end
    // Load then store to the same word: the load sees the old contents.
    op = mkOp(1, 1, 0, 3'd2, 5'd12, 32'h20, 32'd0);
    modelOp(op, e, ld);
    runOp(op, oA, oB, bub, s1, s2, sA);
    runOp(mkOp(0, 0, 1, 3'd2, 5'd0, 32'h20, 32'hCAFEF00D), oA, oB, bub, s1, s2, sA);
    nTotal++; if (s1 !== 1'b0) $display("FAIL store_stall got %b want 0", s1); else nPass++;
    modelOp(mkOp(0, 0, 1, 3'd2, 5'd0, 32'h20, 32'hCAFEF00D), e, ld);
    runOp(mkOp(1, 1, 0, 3'd2, 5'd13, 32'h20, 32'd0), oA, oB, bub, s1, s2, sA);
    nTotal++; if ({oA.data, oB.data} !== {32'hCAFEF00D, 32'hCAFEF00D})
      $display("FAIL ld_after_st got %h %h want cafef00d", oA.data, oB.data); else nPass++;
  endtask

  task automatic test_wrap_and_rst_wait;
    wbT oA, oB, bub, e;
    logic s1, s2, sA, ld;
    modelOp(mkOp(0, 0, 1, 3'd2, 5'd0, 32'h400, 32'h1234), e, ld);
    runOp(mkOp(0, 0, 1, 3'd2, 5'd0, 32'h400, 32'h1234), oA, oB, bub, s1, s2, sA);
    runOp(mkOp(1, 1, 0, 3'd2, 5'd14, 32'h0, 32'd0), oA, oB, bub, s1, s2, sA);
    nTotal++; if ({oA.data, oB.data} !== {32'h1234, 32'h1234})
      $display("FAIL wrap got %h %h want 00001234", oA.data, oB.data); else nPass++;
    // Reset while the registered-read instance waits for its data.
    @(negedge clk);
    drive(mkOp(1, 1, 0, 3'd2, 5'd15, 32'h0, 32'd0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    nTotal++; if (stallB !== 1'b0) $display("FAIL rstwait_stall got %b want 0", stallB); else nPass++;
    @(posedge clk);
    #1;
    nTotal++; if ({wA, wB} !== '0) $display("FAIL rstwait_w got %h %h want 0", wA, wB); else nPass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nTotal++; if (stallB !== 1'b1) $display("FAIL rstwait_idle got %b want 1", stallB); else nPass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    nTotal++; if ({wB.data, wB.rd, wB.regwrite} !== {32'h1234, 5'd15, 1'b1})
      $display("FAIL rstwait_retry got %h %0d %b want 1234 15 1", wB.data, wB.rd, wB.regwrite); else nPass++;
  endtask

  task automatic test_random;
    wbT oA, oB, bub, e;
    logic s1, s2, sA, ld;
    logic [2:0] good [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    opT op;
    int kind;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      op = mkOp(1'($urandom), kind < 5 || kind == 9, kind >= 5 && kind < 9, good[$urandom_range(0, 4)],
                5'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 9) == 0) op.f3 = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'(6 + $urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) op.addr[1:0] = 2'd0;
      if (kind == 9) op.mw = 1'b1;
      op.wbsel = 2'($urandom);
      modelOp(op, e, ld);
      runOp(op, oA, oB, bub, s1, s2, sA);
      nTotal++; if (keepData(oA, ld) !== keepData(e, ld)) $display("FAIL rand%0d_A got %h want %h", n, oA, e); else nPass++;
      nTotal++; if (keepData(oB, ld) !== keepData(e, ld)) $display("FAIL rand%0d_B got %h want %h", n, oB, e); else nPass++;
      nTotal++; if ({sA, s1, s2} !== {1'b0, ld, 1'b0}) $display("FAIL rand%0d_stall got %b want %b", n, {sA, s1, s2}, {1'b0, ld, 1'b0}); else nPass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    test_reset;
    test_fill;
    test_word;
    test_subword;
    test_sb;
    test_misalign;
    test_back_to_back;
    test_wrap_and_rst_wait;
    test_random;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
